// File: rtl/mem_io_responder_if.sv
// Byte-serial memory port plus the UART-side FIFO handshakes and the halt flag.
// The master modport is the memory controller/harness side; the slave modport is the responder.
interface mem_io_responder_if;
    logic        ram_rw;
    logic [31:0] ram_addr;
    logic [7:0]  ram_w_data;
    logic [7:0]  ram_r_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        halt;

    modport master (
        output ram_rw, ram_addr, ram_w_data, tx_ready, rx_valid, rx_data,
        input  ram_r_data, tx_valid, tx_data, rx_ready, halt
    );

    modport slave (
        input  ram_rw, ram_addr, ram_w_data, tx_ready, rx_valid, rx_data,
        output ram_r_data, tx_valid, tx_data, rx_ready, halt
    );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder: decodes byte accesses into a sync RAM or an I/O window (UART FIFOs, status, halt).
// Latency: read data registered, exactly 1 cycle after the address; writes take effect at the edge.
// Backpressure: none on the memory port; TX full drops bytes (sticky ovf), rx_ready deasserts when RX is full.
module mem_io_responder #(
    parameter int RAM_ADDR_W     = 17,
    parameter int FIFO_DEPTH_LOG = 3
) (
    input  logic                clock,
    input  logic                reset,
    mem_io_responder_if.slave   bus
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
    localparam logic [FIFO_DEPTH_LOG:0] CNT_FULL = DEPTH[FIFO_DEPTH_LOG:0];

    logic [7:0] ram [0:(1<<RAM_ADDR_W)-1];
    logic [7:0] tx_mem [0:DEPTH-1];
    logic [7:0] rx_mem [0:DEPTH-1];

    logic [FIFO_DEPTH_LOG-1:0] tx_rd, tx_wr, rx_rd, rx_wr;
    logic [FIFO_DEPTH_LOG:0]   tx_cnt, rx_cnt;
    logic                      tx_ovf;
    logic                      halt_q;
    logic [7:0]                r_data_q;

    logic io_sel, reg_data, reg_stat;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop, tx_drop, stat_rd;
    logic [7:0] status, rd_mux;
    logic unused_addr_bits;

    assign unused_addr_bits = ^bus.ram_addr[31:18];

    assign io_sel   = (bus.ram_addr[17:16] == 2'b11);
    assign reg_data = io_sel && (bus.ram_addr[15:0] == 16'h0000);
    assign reg_stat = io_sel && (bus.ram_addr[15:0] == 16'h0004);

    assign tx_full  = (tx_cnt == CNT_FULL);
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == CNT_FULL);
    assign rx_empty = (rx_cnt == '0);

    // Full/empty come from the pre-edge count, so a same-cycle pop never rescues a push into a full FIFO.
    assign tx_push = reg_data && bus.ram_rw && !tx_full;
    assign tx_drop = reg_data && bus.ram_rw && tx_full;
    assign tx_pop  = !tx_empty && bus.tx_ready;
    assign rx_push = bus.rx_valid && !rx_full;
    assign rx_pop  = reg_data && !bus.ram_rw && !rx_empty;
    assign stat_rd = reg_stat && !bus.ram_rw;

    assign status = {5'b0, tx_ovf, !rx_empty, tx_full};

    assign bus.tx_valid   = !tx_empty;
    assign bus.tx_data    = tx_mem[tx_rd];
    assign bus.rx_ready   = !rx_full;
    assign bus.halt       = halt_q;
    assign bus.ram_r_data = r_data_q;

    always_comb begin
        rd_mux = 8'h00;
        if (!io_sel)
            rd_mux = ram[bus.ram_addr[RAM_ADDR_W-1:0]];
        else if (reg_data)
            rd_mux = rx_empty ? 8'h00 : rx_mem[rx_rd];
        else if (reg_stat)
            rd_mux = status;
    end

    // Storage arrays carry no reset; RAM contents survive a reset.
    always_ff @(posedge clock) begin
        if (bus.ram_rw && !io_sel)
            ram[bus.ram_addr[RAM_ADDR_W-1:0]] <= bus.ram_w_data;
        if (tx_push)
            tx_mem[tx_wr] <= bus.ram_w_data;
        if (rx_push)
            rx_mem[rx_wr] <= bus.rx_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data_q <= 8'h00;
            halt_q   <= 1'b0;
            tx_ovf   <= 1'b0;
            tx_rd    <= '0;
            tx_wr    <= '0;
            tx_cnt   <= '0;
            rx_rd    <= '0;
            rx_wr    <= '0;
            rx_cnt   <= '0;
        end else begin
            if (!bus.ram_rw)
                r_data_q <= rd_mux;
            if (reg_stat && bus.ram_rw)
                halt_q <= 1'b1;
            if (tx_drop)
                tx_ovf <= 1'b1;
            else if (stat_rd)
                tx_ovf <= 1'b0;
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            tx_cnt <= tx_cnt + {{FIFO_DEPTH_LOG{1'b0}}, tx_push}
                             - {{FIFO_DEPTH_LOG{1'b0}}, tx_pop};
            rx_cnt <= rx_cnt + {{FIFO_DEPTH_LOG{1'b0}}, rx_push}
                             - {{FIFO_DEPTH_LOG{1'b0}}, rx_pop};
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: reads push their expected byte, the next edge pops and compares.
module tb_mem_io_responder;
    logic clock;
    logic reset;
    mem_io_responder_if bus ();

    mem_io_responder #(.RAM_ADDR_W(17), .FIFO_DEPTH_LOG(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_rd;

    localparam logic [31:0] IO_DATA = 32'h0003_0000;
    localparam logic [31:0] IO_STAT = 32'h0003_0004;
    localparam logic [31:0] IO_NONE = 32'h0003_0008;

    // One bus access; reads are scored one cycle later, writes must leave ram_r_data unchanged.
    task automatic bus_op(input logic rw, input logic [31:0] addr, input logic [7:0] wd,
                          input logic [7:0] exp, input string name);
        logic [7:0] want;
        bus.ram_rw     = rw;
        bus.ram_addr   = addr;
        bus.ram_w_data = wd;
        if (!rw) exp_q.push_back(exp);
        @(posedge clock);
        #1;
        if (!rw) begin
            want    = exp_q.pop_front();
            last_rd = want;
        end else begin
            want = last_rd;
        end
        n_checks++;
        if (bus.ram_r_data !== want) begin
            n_fail++;
            $display("FAIL %s addr=%h: ram_r_data=%h expected %h", name, addr, bus.ram_r_data, want);
        end
    endtask

    task automatic idle(input string name);
        bus_op(1'b0, IO_NONE, 8'h00, 8'h00, name);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.ram_rw = 1'b0; bus.ram_addr = IO_NONE; bus.ram_w_data = 8'h00;
        bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        last_rd = 8'h00;
        #1;
        n_checks++;
        if (bus.ram_r_data !== 8'h00 || bus.halt !== 1'b0 || bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: r_data=%h halt=%b tx_valid=%b rx_ready=%b expected 00 0 0 1",
                     bus.ram_r_data, bus.halt, bus.tx_valid, bus.rx_ready);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        idle("reset_idle");
    endtask

    task automatic test_ram_roundtrip;
        logic [7:0] pat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) bus_op(1'b1, 32'h100 + i, pat[i], 8'h00, "ram_wr_hold");
        for (int i = 0; i < 4; i++) bus_op(1'b0, 32'h100 + i, 8'h00, pat[i], "ram_rd");
    endtask

    task automatic test_read_after_write;
        bus_op(1'b1, 32'h2000, 8'hA5, 8'h00, "raw_wr");
        bus_op(1'b0, 32'h2000, 8'h00, 8'hA5, "raw_rd");
    endtask

    task automatic test_tx_overflow;
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) bus_op(1'b1, IO_DATA, 8'(i), 8'h00, "tx_fill");
        bus_op(1'b0, IO_STAT, 8'h00, 8'h05, "tx_status_ovf");
        bus_op(1'b0, IO_STAT, 8'h00, 8'h01, "tx_status_clr");
        bus.tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            n_checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(i)) begin
                n_fail++;
                $display("FAIL tx_drain: valid=%b data=%h expected 1 %h", bus.tx_valid, bus.tx_data, 8'(i));
            end
            idle("tx_drain_idle");
        end
        n_checks++;
        if (bus.tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_empty: tx_valid=%b expected 0", bus.tx_valid);
        end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_rx_wrap;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (bus.rx_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rx_ready_fill: rx_ready=%b expected 1 at push %0d", bus.rx_ready, i);
            end
            bus.rx_data = 8'hC0 + 8'(i);
            idle("rx_push_idle");
        end
        bus.rx_valid = 1'b0;
        n_checks++;
        if (bus.rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_ready_full: rx_ready=%b expected 0", bus.rx_ready);
        end
        for (int i = 0; i < 4; i++) bus_op(1'b0, IO_DATA, 8'h00, 8'hC0 + 8'(i), "rx_pop_a");
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.rx_data = 8'hD0 + 8'(i);
            idle("rx_push2_idle");
        end
        bus.rx_valid = 1'b0;
        for (int i = 0; i < 4; i++) bus_op(1'b0, IO_DATA, 8'h00, 8'hC4 + 8'(i), "rx_pop_wrap");
        for (int i = 0; i < 4; i++) bus_op(1'b0, IO_DATA, 8'h00, 8'hD0 + 8'(i), "rx_pop_b");
        bus_op(1'b0, IO_DATA, 8'h00, 8'h00, "rx_pop_empty");
    endtask

    task automatic test_simultaneous;
        logic [7:0] order [3] = '{8'hBB, 8'hCC, 8'hDD};
        bus.tx_ready = 1'b0;
        bus_op(1'b1, IO_DATA, 8'hAA, 8'h00, "sim_fill");
        bus_op(1'b1, IO_DATA, 8'hBB, 8'h00, "sim_fill");
        bus_op(1'b1, IO_DATA, 8'hCC, 8'h00, "sim_fill");
        bus.tx_ready = 1'b1;
        bus_op(1'b1, IO_DATA, 8'hDD, 8'h00, "sim_push_pop");
        bus.tx_ready = 1'b0;
        bus_op(1'b0, IO_STAT, 8'h00, 8'h00, "sim_status");
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== order[i]) begin
                n_fail++;
                $display("FAIL sim_order: valid=%b data=%h expected 1 %h", bus.tx_valid, bus.tx_data, order[i]);
            end
            idle("sim_drain_idle");
        end
        n_checks++;
        if (bus.tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_count: tx_valid=%b expected 0 after 3 pops", bus.tx_valid);
        end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_halt_reset;
        n_checks++;
        if (bus.halt !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_pre: halt=%b expected 0", bus.halt);
        end
        bus_op(1'b1, IO_STAT, 8'h5A, 8'h00, "halt_wr");
        n_checks++;
        if (bus.halt !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_set: halt=%b expected 1", bus.halt);
        end
        bus_op(1'b1, IO_DATA, 8'h77, 8'h00, "pre_reset_tx");
        bus_op(1'b0, 32'h100, 8'h00, 8'h11, "pre_reset_rd");
        #2 reset = 1'b0;
        #1;
        last_rd = 8'h00;
        n_checks++;
        if (bus.halt !== 1'b0 || bus.ram_r_data !== 8'h00 || bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: halt=%b r_data=%h tx_valid=%b rx_ready=%b expected 0 00 0 1",
                     bus.halt, bus.ram_r_data, bus.tx_valid, bus.rx_ready);
        end
        #1 reset = 1'b1;
        bus_op(1'b0, IO_STAT, 8'h00, 8'h00, "post_reset_status");
        bus_op(1'b0, 32'h100, 8'h00, 8'h11, "ram_persist_a");
        bus_op(1'b0, 32'h103, 8'h00, 8'h44, "ram_persist_b");
        bus_op(1'b0, 32'h2000, 8'h00, 8'hA5, "ram_persist_c");
    endtask

    initial begin
        test_reset();
        test_ram_roundtrip();
        test_read_after_write();
        test_tx_overflow();
        test_rx_wrap();
        test_simultaneous();
        test_halt_reset();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the CPU's byte-serial memory port. The memory controller drives the port as initiator, one byte per cycle. This block answers it. It decodes each address into either a synchronous byte RAM or a small memory-mapped I/O window, and returns read data one cycle after the address. The I/O window holds a UART transmit FIFO, a UART receive FIFO, a status byte and a halt flag.

## Interface
Parameters:
- `RAM_ADDR_W`, default 17: RAM byte-address width; RAM depth is 2^RAM_ADDR_W bytes.
- `FIFO_DEPTH_LOG`, default 3: log2 of the depth of each FIFO (8 entries each).

Ports:
- `clock`  in  1  the single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ram_rw`  in  1  1 = write this cycle, 0 = read.
- `ram_addr`  in  32  byte address presented this cycle.
- `ram_w_data`  in  8  write byte; valid when `ram_rw`=1.
- `ram_r_data`  out  8  registered read byte for the address presented in the previous cycle.
- `tx_valid`  out  1  transmit FIFO non-empty.
- `tx_data`  out  8  head of the transmit FIFO.
- `tx_ready`  in  1  UART accepts `tx_data` this cycle.
- `rx_valid`  in  1  UART offers `rx_data`.
- `rx_data`  in  8  received byte.
- `rx_ready`  out  1  receive FIFO not full.
- `halt`  out  1  sticky halt request, for the simulation harness.

## Operation
Address decode:
- I/O when `ram_addr[17:16]`==2'b11 (0x30000–0x3FFFF).
- RAM otherwise, indexed by `ram_addr[RAM_ADDR_W-1:0]`.

RAM behaviour:
- Write: the byte is stored at the clock edge.
- Read: the byte is registered into `ram_r_data`.
- RAM contents are not reset.

I/O map:
- 0x30000 write: push `ram_w_data` into the TX FIFO. If the TX FIFO is full before the edge, the byte is dropped and sticky `tx_ovf` is set. This holds even if `tx_ready` pops in the same cycle.
- 0x30000 read: pop the RX FIFO head into `ram_r_data`. If the FIFO is empty before the edge, return 0x00 and do not pop. There is no bypass of a same-cycle push.
- 0x30004 read: return status {5'b0, `tx_ovf`, rx_nonempty, tx_full}, then clear `tx_ovf`.
- 0x30004 write: set `halt`=1 (sticky); the data is ignored.
- Any other I/O address: reads return 0x00 and writes are ignored.

Side effects are applied on every cycle the access is presented. The initiator presents each I/O address once per transfer.

FIFOs:
- Both are circular buffers with read/write pointers of FIFO_DEPTH_LOG bits and a count of FIFO_DEPTH_LOG+1 bits.
- Pointers wrap modulo the depth.
- Full and empty are judged on the pre-edge count.
- A push and a pop in the same cycle are both performed; the count is unchanged.
- TX FIFO: pop when `tx_valid` && `tx_ready`. `tx_data` is the combinational head.
- RX FIFO: push when `rx_valid` && `rx_ready`. `rx_ready` = !rx_full, combinational.

## Timing
- Read latency is exactly 1 cycle: address A presented in cycle N gives `ram_r_data` = mem[A] in cycle N+1. The output holds until the next read.
- A write cycle leaves `ram_r_data` unchanged.
- Read-after-write: a write to A in cycle N followed by a read of A in cycle N+1 returns the new byte in cycle N+2.
- No wait states; every cycle is one accepted access.
- Reset asserted (low), asynchronously:
  - `ram_r_data`=0 and `halt`=0.
  - `tx_ovf`=0 and both FIFOs empty.
  - So `tx_valid`=0, `tx_data`=stale/don't-care, `rx_ready`=1.
- Reset mid-transfer discards FIFO contents; RAM contents persist.
- Reset release is sampled synchronously to `clock` by the surrounding design.

## Test plan
- RAM round trip: write 0x11, 0x22, 0x33, 0x44 to 0x100–0x103 on consecutive cycles, then read 0x100–0x103 consecutively. `ram_r_data` is 0x11, 0x22, 0x33, 0x44 one cycle after each address.
- Read-after-write: write 0xA5 to 0x2000, read 0x2000 in the next cycle. 0xA5 appears in the following cycle.
- TX FIFO fill and overflow: with `tx_ready`=0, write 0x30000 nine times with data 1..9. Status read returns 0x05 (tx_full, ovf). A second status read returns 0x01. With `tx_ready`=1, `tx_data` drains 1..8 and then `tx_valid`=0.
- RX FIFO wrap: push 0xC0–0xC7 via `rx_valid`. `rx_ready` goes 0 after the 8th push. Read 0x30000 four times (0xC0–0xC3), push 0xD0–0xD3, then read eight times. The reads return 0xC4–0xC7 then 0xD0–0xD3, and a ninth read returns 0x00.
- Simultaneous: with the TX FIFO holding 3 bytes, `tx_ready`=1 while writing 0x30000. The count stays 3 and order is preserved.
- Halt and reset: write 0x30004 and `halt` rises next cycle. Assert `reset` asynchronously mid-cycle: `halt`, `ram_r_data`, `tx_valid` and the status byte read back as 0 immediately, and RAM data written earlier still reads back.
